// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the pipelined instruction memory.
// Response record is instr(32) + fault(1) + cause(2).
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_e;

  typedef struct packed {
    logic [31:0]  instr;
    logic         fault;
    fault_cause_e cause;
  } rsp_t;

  localparam int RSP_W = 32 + 1 + 2;

  localparam rsp_t RSP_IDLE = '{
    instr: NOP_INSTR,
    fault: 1'b0,
    cause: FC_NONE
  };

endpackage

// File: rtl/instr_mem_pipe_if.sv
// Fetch request / response handshake bundle.
// slave = memory side, master = fetch unit side.
interface instr_mem_pipe_if #(
  parameter int ADDR_W = 32
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_pc;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_instr;
  logic              o_fault;
  logic [1:0]        o_fault_cause;

  modport slave (
    input  i_req_valid, i_pc, i_rsp_ready,
    output o_req_ready, o_rsp_valid,
    output o_instr, o_fault, o_fault_cause
  );

  modport master (
    output i_req_valid, i_pc, i_rsp_ready,
    input  o_req_ready, o_rsp_valid,
    input  o_instr, o_fault, o_fault_cause
  );
endinterface

// File: rtl/instr_rsp_fifo.sv
// Two-entry in-order response buffer with occupancy count.
// Head shows the idle record when empty.
module instr_rsp_fifo
  import instr_mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push_valid,
  output logic       o_push_ready,
  input  rsp_t       i_push_data,
  output logic       o_pop_valid,
  input  logic       i_pop_ready,
  output rsp_t       o_pop_data,
  output logic [1:0] o_count
);

  logic [1:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  rsp_t       ent_q [2];
  logic       push, pop;

  assign o_push_ready = (cnt_q != 2'd2);
  assign o_pop_valid  = (cnt_q != 2'd0);
  assign push = i_push_valid && o_push_ready;
  assign pop  = i_pop_ready && o_pop_valid;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = ~wr_q;
    if (pop)  rd_d = ~rd_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  // Payload needs no reset: it is masked by the count.
  always_ff @(posedge i_clk) begin
    if (push) ent_q[wr_q] <= i_push_data;
  end

  assign o_pop_data = o_pop_valid ? ent_q[rd_q] : RSP_IDLE;
  assign o_count    = cnt_q;

endmodule

// File: rtl/instr_mem_pipe.sv
// Synchronous instruction memory: fetch decode, fault
// classification, byte-enabled programming port.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  instr_mem_pipe_if.slave   bus,
  input  logic              i_prog_en,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [31:0]       i_prog_data,
  input  logic [3:0]        i_prog_be
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN =
    ADDR_W'(DEPTH_WORDS * 4);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] f_off, p_off;
  logic [IDX_W-1:0]  f_idx, p_idx;
  logic              f_mis, f_rng, p_ok;
  logic              req_ready, push;
  logic [1:0]        count;
  rsp_t              push_data, head;

  assign f_off = bus.i_pc - BASE_ADDR;
  assign f_idx = f_off[IDX_W+1:2];
  assign p_off = i_prog_addr - BASE_ADDR;
  assign p_idx = p_off[IDX_W+1:2];
  assign p_ok  = (p_off < SPAN);

  // Misalignment wins, so range is only flagged when aligned.
  assign f_mis = (bus.i_pc[1:0] != 2'b00);
  assign f_rng = !f_mis && (f_off >= SPAN);

  always_comb begin
    push_data = RSP_IDLE;
    unique case (1'b1)
      f_mis: begin
        push_data.fault = 1'b1;
        push_data.cause = FC_MISALIGN;
      end
      f_rng: begin
        push_data.fault = 1'b1;
        push_data.cause = FC_RANGE;
      end
      default: push_data.instr = mem_q[f_idx];
    endcase
  end

  assign req_ready = !i_prog_en && (count != 2'd2);
  assign push      = bus.i_req_valid && req_ready;

  always_ff @(posedge i_clk) begin
    if (i_prog_en && p_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (i_prog_be[b])
          mem_q[p_idx][8*b +: 8] <= i_prog_data[8*b +: 8];
      end
    end
  end

  instr_rsp_fifo u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push_valid (push),
    .o_push_ready (),
    .i_push_data  (push_data),
    .o_pop_valid  (bus.o_rsp_valid),
    .i_pop_ready  (bus.i_rsp_ready),
    .o_pop_data   (head),
    .o_count      (count)
  );

  assign bus.o_req_ready   = req_ready;
  assign bus.o_instr       = head.instr;
  assign bus.o_fault       = head.fault;
  assign bus.o_fault_cause = head.cause;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench for instr_mem_pipe.
// Expected responses are queued on accept and popped on delivery.
module tb_instr_mem_pipe;

  localparam logic [31:0] BASE = 32'h64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  cause;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_en = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [3:0]  prog_be = '0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;
  exp_t sb [$];
  logic [31:0] mdl [256];

  instr_mem_pipe_if #(.ADDR_W(32)) bus ();

  instr_mem_pipe #(
    .ADDR_W      (32),
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h64)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .i_prog_en   (prog_en),
    .i_prog_addr (prog_addr),
    .i_prog_data (prog_data),
    .i_prog_be   (prog_be)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic exp_t expect_of(logic [31:0] pc);
    exp_t e;
    logic [31:0] off;
    off = pc - BASE;
    e.cyc = cyc;
    e.instr = NOP;
    e.fault = 1'b1;
    if (pc[1:0] != 2'b00) e.cause = 2'b01;
    else if (off >= 32'd1024) e.cause = 2'b10;
    else begin
      e.instr = mdl[off[9:2]];
      e.fault = 1'b0;
      e.cause = 2'b00;
    end
    return e;
  endfunction

  // Monitor samples at the falling edge, i.e. what the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("instr", bus.o_instr, e.instr);
          chk("fault", bus.o_fault, e.fault);
          chk("cause", bus.o_fault_cause, e.cause);
          if (lat_mode) chk("latency", cyc - e.cyc, 1);
        end
      end
      if (prog_en && (prog_addr - BASE) < 32'd1024) begin
        logic [31:0] off;
        off = prog_addr - BASE;
        for (int b = 0; b < 4; b++)
          if (prog_be[b])
            mdl[off[9:2]][8*b +: 8] = prog_data[8*b +: 8];
      end
      if (bus.i_req_valid && bus.o_req_ready)
        sb.push_back(expect_of(bus.i_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(logic [31:0] a, logic [31:0] d,
                      logic [3:0] be);
    prog_en = 1'b1;
    prog_addr = a;
    prog_data = d;
    prog_be = be;
    #1;
    chk("prog_ready", bus.o_req_ready, 0);
    step();
    prog_en = 1'b0;
    prog_be = '0;
  endtask

  task automatic fetch(logic [31:0] pc);
    int n;
    n = 0;
    bus.i_req_valid = 1'b1;
    bus.i_pc = pc;
    while (!bus.o_req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("req_timeout", 1, 0);
    step();
    bus.i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] head;
    bus.i_req_valid = 1'b0;
    bus.i_pc = '0;
    bus.i_rsp_ready = 1'b1;
    #2;
    chk("rst_valid", bus.o_rsp_valid, 0);
    chk("rst_instr", bus.o_instr, NOP);
    chk("rst_fault", bus.o_fault, 0);
    chk("rst_cause", bus.o_fault_cause, 0);
    chk("rst_ready", bus.o_req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    prog(32'h64, 32'h00A00093, 4'hF);
    prog(32'h68, 32'h00B00113, 4'hF);
    prog(32'h6C, 32'h002081B3, 4'hF);
    prog(32'h70, 32'h00000013, 4'hF);

    lat_mode = 1'b1;
    for (int i = 0; i < 4; i++) fetch(32'h64 + 4 * i);
    drain();
    lat_mode = 1'b0;

    fetch(32'h66);
    fetch(32'h60);
    fetch(32'h64 + 1024);
    fetch(32'h61);
    drain();

    bus.i_rsp_ready = 1'b0;
    fetch(32'h64);
    fetch(32'h68);
    bus.i_req_valid = 1'b1;
    bus.i_pc = 32'h6C;
    #0;
    chk("bp_ready", bus.o_req_ready, 0);
    head = bus.o_instr;
    chk("bp_head", head, 32'h00A00093);
    repeat (3) begin
      step();
      chk("bp_stable", bus.o_instr, head);
      chk("bp_valid", bus.o_rsp_valid, 1);
    end
    chk("bp_still", bus.o_req_ready, 0);
    bus.i_rsp_ready = 1'b1;
    fetch(32'h6C);
    drain();

    bus.i_rsp_ready = 1'b0;
    fetch(32'h64);
    prog(32'h64, 32'h0000_00FF, 4'b0001);
    prog(32'h64 + 1024, 32'hDEAD_BEEF, 4'hF);
    drain();
    fetch(32'h64);
    drain();

    bus.i_rsp_ready = 1'b0;
    fetch(32'h68);
    fetch(32'h6C);
    chk("pre_rst_valid", bus.o_rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.o_rsp_valid, 0);
    chk("async_instr", bus.o_instr, NOP);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_valid", bus.o_rsp_valid, 0);
    chk("post_ready", bus.o_req_ready, 1);
    fetch(32'h68);
    fetch(32'h6C);
    chk("post_two", bus.o_req_ready, 0);
    drain();
    fetch(32'h64);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_mem_pipe.md
# instr_mem_pipe

Parametrised, synchronous instruction memory for the pipelined core: the successor to the combinational single-cycle instruction ROM. Accepts byte-addressed fetch requests over a valid/ready handshake, returns instructions in order one cycle later through a 2-entry response buffer, flags misaligned and out-of-range fetches, and exposes a word-write programming port for boot loading.

## Interface
- `ADDR_W`, 32: fetch/program address width (bytes).
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0064: byte address of word 0; word-aligned.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_req_valid`  in  1  fetch request present.
- `o_req_ready`  out  1  fetch request can be accepted this cycle.
- `i_pc`  in  ADDR_W  fetch byte address.
- `o_rsp_valid`  out  1  response at head of buffer.
- `i_rsp_ready`  in  1  consumer takes response.
- `o_instr`  out  32  instruction word, little-endian.
- `o_fault`  out  1  head response is a faulted fetch.
- `o_fault_cause`  out  2  01 misaligned, 10 out of range, 00 none.
- `i_prog_en`  in  1  programming write strobe.
- `i_prog_addr`  in  ADDR_W  programming byte address; bits [1:0] ignored.
- `i_prog_data`  in  32  word to write.
- `i_prog_be`  in  4  byte enables; bit n writes `i_prog_data[8n+7:8n]`.

## Operation
- Request accepted when `i_req_valid && o_req_ready`; response accepted when `o_rsp_valid && i_rsp_ready`.
- `o_req_ready = !i_prog_en && (occupancy < 2)`. Occupancy counts accepted-but-not-consumed responses, 0..2.
- Occupancy: +1 on request accept, −1 on response accept, unchanged when both occur in the same cycle.
- Word index = `(i_pc − BASE_ADDR) >> 2`, computed at ADDR_W bits and wrapping modulo 2^ADDR_W.
- Fault classification at accept, misaligned taking priority:
  - `i_pc[1:0] != 0` → cause 01.
  - `i_pc − BASE_ADDR >= DEPTH_WORDS*4` (unsigned; covers pc below base) → cause 10.
- A faulted response carries `o_instr = 32'h0000_0013` (NOP) and `o_fault = 1`; memory is not read.
- Responses are returned strictly in request order. No request is ever dropped or duplicated.
- Programming: on `i_prog_en` with an in-range address, enabled bytes are written at the edge. Out-of-range programming writes are ignored silently. Programming has priority over fetch: requests are refused that cycle.
- Read data is captured at the accept edge. A later programming write to the same word does not alter an already-buffered response.
- Memory contents are not cleared by reset; only control state resets.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): `o_rsp_valid=0`, `o_instr=32'h0000_0013`, `o_fault=0`, `o_fault_cause=00`, occupancy 0, `o_req_ready=!i_prog_en`.
- Latency: request accepted at edge N → `o_rsp_valid=1` with data in the cycle after edge N. There is no combinational path from `i_pc` to `o_instr`.
- Throughput: with `i_rsp_ready` held at 1, one fetch per cycle is sustained indefinitely.
- Backpressure: with `i_rsp_ready=0`, at most 2 further requests are accepted, then `o_req_ready=0`. The head `o_instr`, `o_fault` and `o_fault_cause` stay stable while `o_rsp_valid && !i_rsp_ready`.
- `o_req_ready` depends only on registered occupancy and `i_prog_en`, never on `i_req_valid` or `i_rsp_ready`.
- Reset asserted mid-stream: buffered responses are discarded, and `o_rsp_valid` drops immediately (asynchronously).

## Structure
- Package/header `instr_mem_pkg`: `NOP_INSTR = 32'h0000_0013`, the fault cause codes `FC_NONE`, `FC_MISALIGN`, `FC_RANGE`, and the response record width (32+1+2).
- Sub-module `instr_rsp_fifo`: 2-entry, 35-bit, in-order response buffer with occupancy counter and valid/ready on both sides.
- Top level holds the memory array, address/fault decode and programming write.

## Test plan
- Program words 0..3 at base 0x64 with 0x00A00093, 0x00B00113, 0x002081B3, 0x00000013. Fetch pc 0x64..0x70 back-to-back with `i_rsp_ready=1` → four responses on consecutive cycles, each one cycle after accept, matching data, `o_fault=0`.
- Fetch pc 0x66 → NOP, `o_fault=1`, cause 01. Fetch pc 0x60, then pc 0x64+1024 → cause 10 for both.
- Hold `i_rsp_ready=0` and request 0x64, 0x68, 0x6C → first two accepted, `o_req_ready=0` on the third, head stable. Release → 0x64 then 0x68 data delivered, then the third is accepted.
- Buffer a fetch of 0x64, then program 0x64 with `i_prog_be=4'b0001`, data 0xFF → buffered response still 0x00A00093. A refetch returns 0x00A000FF. `o_req_ready=0` during the prog cycle.
- Assert `i_rst_n=0` with 2 responses buffered → `o_rsp_valid` falls without a clock edge. After release, occupancy is 0 and memory contents are intact on refetch.
